// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter for the register-file write port (WE3/AD3/WD3).
// Define WB_SCOREBOARD_EN to enable the per-register pending-write scoreboard.
module wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        a_valid,
    input  logic [ADDRESS_WIDTH-1:0]    a_rd,
    input  logic [DATA_WIDTH-1:0]       a_data,
    output logic                        a_ready,
    input  logic                        b_valid,
    input  logic [ADDRESS_WIDTH-1:0]    b_rd,
    input  logic [DATA_WIDTH-1:0]       b_data,
    output logic                        b_ready,
    input  logic                        wb_stall,
    output logic                        WE3,
    output logic [ADDRESS_WIDTH-1:0]    AD3,
    output logic [DATA_WIDTH-1:0]       WD3,
    input  logic                        claim_valid,
    input  logic [ADDRESS_WIDTH-1:0]    claim_rd,
    output logic [2**ADDRESS_WIDTH-1:0] busy,
    output logic                        claim_err
);

    localparam int NREG = 2**ADDRESS_WIDTH;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e                   last_grant_q, last_grant_d;
    logic                     grant_a, grant_b, xfer, retire;
    logic [ADDRESS_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;

    // Ready depends only on valids, stall and last_grant, never on itself.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && !wb_stall) begin
            if (a_valid && b_valid) begin
                grant_a = (last_grant_q == GRANT_B);
                grant_b = (last_grant_q == GRANT_A);
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    always_comb begin
        xfer         = grant_a | grant_b;
        sel_rd       = grant_b ? b_rd : a_rd;
        sel_data     = grant_b ? b_data : a_data;
        retire       = xfer && (sel_rd != '0);
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = grant_b ? GRANT_B : GRANT_A;
        end
        we_d = retire;
        ad_d = xfer ? sel_rd : ad_q;
        wd_d = xfer ? sel_data : wd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
            we_q         <= 1'b0;
            ad_q         <= '0;
            wd_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            ad_q         <= ad_d;
            wd_q         <= wd_d;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign WE3     = we_q;
    assign AD3     = ad_q;
    assign WD3     = wd_q;

`ifdef WB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q, err_d;
    logic            claim;

    // A claim and a retire of the same register: the new claim wins.
    always_comb begin
        claim  = claim_valid && (claim_rd != '0);
        busy_d = busy_q;
        err_d  = err_q;
        if (retire) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (claim) begin
            if (busy_q[claim_rd] && !(retire && sel_rd == claim_rd)) begin
                err_d = 1'b1;
            end
            busy_d[claim_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy      = busy_q;
    assign claim_err = err_q;
`else
    logic unused_claim;
    assign unused_claim = ^{claim_valid, claim_rd, retire, NREG[0]};
    assign busy         = '0;
    assign claim_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, scoreboard
// sequences and randomized traffic against a behavioural model.
module tb_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, wb_stall = 1'b0;
    logic [AW-1:0] a_rd = '0, b_rd = '0, claim_rd = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          claim_valid = 1'b0;
    logic          a_ready, b_ready, WE3, claim_err;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;
    logic [NR-1:0] busy;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .wb_stall(wb_stall),
        .WE3(WE3), .AD3(AD3), .WD3(WD3),
        .claim_valid(claim_valid), .claim_rd(claim_rd),
        .busy(busy), .claim_err(claim_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who was served last, what the port should show,
    // which registers have a claimed-but-unwritten result.
    bit            m_last_b = 1'b1;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_ad = '0;
    logic [DW-1:0] m_wd = '0;
    bit            m_busy [NR];
    bit            m_err = 1'b0;
    bit            s_ar, s_br;

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic step(input bit use_model);
        bit            ga, gb, clm, wr;
        logic [AW-1:0] rd;
        logic [DW-1:0] dat;
        ga = 0;
        gb = 0;
        if (rst_n && !wb_stall) begin
            if (a_valid && b_valid) begin
                if (m_last_b) ga = 1; else gb = 1;
            end else if (a_valid) ga = 1;
            else if (b_valid) gb = 1;
        end
        #1;
        s_ar = a_ready;
        s_br = b_ready;
        if (use_model) begin
            chk("a_ready", a_ready, ga);
            chk("b_ready", b_ready, gb);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_last_b = 1;
            m_we = 0; m_ad = '0; m_wd = '0; m_err = 0;
            for (int i = 0; i < NR; i++) m_busy[i] = 0;
        end else begin
            rd  = gb ? b_rd : a_rd;
            dat = gb ? b_data : a_data;
            wr  = (ga || gb) && rd != 0;
            m_we = wr;
            if (ga || gb) begin
                m_ad = rd; m_wd = dat; m_last_b = gb;
            end
            if (SB) begin
                clm = claim_valid && claim_rd != 0;
                if (clm && m_busy[claim_rd] && !(wr && rd == claim_rd)) m_err = 1;
                if (wr) m_busy[rd] = 0;
                if (clm) m_busy[claim_rd] = 1;
            end
        end
        #1;
        if (use_model) begin
            chk("WE3", WE3, m_we);
            chk("AD3", AD3, m_ad);
            chk("WD3", WD3, m_wd);
            chk("busy", busy, m_busy_vec());
            chk("claim_err", claim_err, m_err);
        end
    endtask

    typedef struct {
        bit            rst;
        bit            av;
        logic [AW-1:0] ard;
        logic [DW-1:0] adat;
        bit            bv;
        logic [AW-1:0] brd;
        logic [DW-1:0] bdat;
        bit            st;
        bit            ear;
        bit            ebr;
        bit            ewe;
        logic [AW-1:0] ead;
        logic [DW-1:0] ewd;
    } vec_t;

    vec_t tbl [10];

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; wb_stall = 0; claim_valid = 0;
        a_rd = '0; b_rd = '0; claim_rd = '0;
    endtask

    initial begin
        tbl[0] = '{0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0, 32'h0};
        tbl[1] = '{0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0, 32'h0};
        tbl[2] = '{1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 1, 0, 1, 3, 32'h11};
        tbl[3] = '{1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 1, 1, 4, 32'h22};
        tbl[4] = '{1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 1, 0, 1, 3, 32'h11};
        tbl[5] = '{1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 1, 1, 4, 32'h22};
        tbl[6] = '{1, 1, 0, 32'hDEAD, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'hDEAD};
        tbl[7] = '{1, 0, 0, 32'h0, 1, 9, 32'h33, 1, 0, 0, 0, 0, 32'hDEAD};
        tbl[8] = '{1, 0, 0, 32'h0, 1, 9, 32'h33, 0, 0, 1, 1, 9, 32'h33};
        tbl[9] = '{1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 9, 32'h33};

        for (int i = 0; i < NR; i++) m_busy[i] = 0;

        for (int i = 0; i < 10; i++) begin
            rst_n = tbl[i].rst;
            a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].adat;
            b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bdat;
            wb_stall = tbl[i].st;
            step(0);
            chk($sformatf("tbl%0d.a_ready", i), s_ar, tbl[i].ear);
            chk($sformatf("tbl%0d.b_ready", i), s_br, tbl[i].ebr);
            chk($sformatf("tbl%0d.WE3", i), WE3, tbl[i].ewe);
            chk($sformatf("tbl%0d.AD3", i), AD3, tbl[i].ead);
            chk($sformatf("tbl%0d.WD3", i), WD3, tbl[i].ewd);
            if (i < 2) chk($sformatf("tbl%0d.busy", i), busy, 0);
        end

        // Scoreboard set / retire / collision sequence
        idle_inputs();
        rst_n = 0; step(1);
        rst_n = 1;
        claim_valid = 1; claim_rd = 5; step(1);
        chk("sb.busy5_set", busy[5], SB);
        claim_valid = 0; step(1);
        a_valid = 1; a_rd = 5; a_data = 32'h55; step(1);
        chk("sb.busy5_clr", busy[5], 0);
        chk("sb.we_rd5", WE3, 1);
        chk("sb.err0", claim_err, 0);
        a_valid = 0;
        claim_valid = 1; claim_rd = 7; step(1);
        chk("sb.busy7_set", busy[7], SB);
        b_valid = 1; b_rd = 7; b_data = 32'h77; step(1);
        chk("sb.b_ready_retire", s_br, 1);
        chk("sb.busy7_keep", busy[7], SB);
        chk("sb.err_still0", claim_err, 0);
        b_valid = 0; step(1);
        chk("sb.err_set", claim_err, SB);
        claim_valid = 0; step(1); step(1);
        chk("sb.err_sticky", claim_err, SB);
        chk("sb.busy0", busy[0], 0);
        rst_n = 0; step(1);
        chk("sb.err_reset", claim_err, 0);
        chk("sb.busy_reset", busy, 0);
        rst_n = 1;

        // Randomized traffic, producers hold requests until accepted
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            wb_stall = ($urandom_range(0, 5) == 0);
            if (!a_valid && $urandom_range(0, 9) < 6) begin
                a_valid = 1; a_rd = AW'($urandom_range(0, 7)); a_data = $urandom;
            end
            if (!b_valid && $urandom_range(0, 9) < 6) begin
                b_valid = 1; b_rd = AW'($urandom_range(0, 7)); b_data = $urandom;
            end
            claim_valid = ($urandom_range(0, 3) == 0);
            claim_rd = AW'($urandom_range(0, 7));
            step(1);
            if (!rst_n || s_ar) a_valid = 0;
            if (!rst_n || s_br) b_valid = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
